// File: rtl/mmu_sequencer.sv
// -----------------------------------------------------------------------------
// mmu_sequencer
//
// Drives an N x N systolic array through one tile operation:
//   1. loads a weight tile into the array column by column (control=1),
//   2. buffers N data beats from the front-end,
//   3. issues the buffered tile to the array with a one-cycle skew per lane,
//   4. captures the skewed bottom-row results and re-aligns them so that one
//      full N-column result vector is presented per data column.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start, w_tile     begin a tile op; weight tile captured on acceptance
//                     (W[r][c] at bits [(c*N+r)*DW +: DW])
//   in_valid/ready    data beat handshake; in_data beat r, byte i = D[i][r]
//   control           to array: 1 = weight load, 0 = compute
//   wt_arr, data_arr  to array weight / data buses (lane i at [i*DW +: DW])
//   res_in            from array bottom row, column j at [j*ACCW +: ACCW]
//   out_valid/data    one strobe per de-skewed result vector
//   busy, done        busy outside IDLE; done pulses once at end of tile
// -----------------------------------------------------------------------------
module mmu_sequencer #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int ACCW    = 24,
  parameter int RES_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*N*DW-1:0]   w_tile,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DW-1:0]     in_data,
  output logic                control,
  output logic [N*DW-1:0]     wt_arr,
  output logic [N*DW-1:0]     data_arr,
  input  logic [N*ACCW-1:0]   res_in,
  output logic                out_valid,
  output logic [N*ACCW-1:0]   out_data,
  output logic                busy,
  output logic                done
);

  localparam int CW     = (N > 1) ? $clog2(N) : 1;
  // Last cycle (issue-relative) on which a result vector is presented.
  localparam int T_LAST = RES_LAT + 2 * N - 1;
  localparam int TW     = $clog2(T_LAST + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_SETTLE = 3'd2,
    S_FILL   = 3'd3,
    S_ISSUE  = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;     // weight column / data beat index
  logic [TW-1:0]              t_q, t_d;         // issue-relative time
  logic [N*N*DW-1:0]          w_q, w_d;
  logic [N-1:0][N*DW-1:0]     dbuf_q, dbuf_d;   // dbuf[r] = data beat r

  logic                       control_q, control_d;
  logic [N*DW-1:0]            wt_arr_q, wt_arr_d;
  logic [N*DW-1:0]            data_arr_q, data_arr_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic [N*ACCW-1:0]          out_data_q, out_data_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  // ---------------------------------------------------------------------------
  // State register: every flop of the controller, including registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      t_q         <= '0;
      w_q         <= '0;
      dbuf_q      <= '0;
      control_q   <= 1'b0;
      wt_arr_q    <= '0;
      data_arr_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      w_q         <= w_d;
      dbuf_q      <= dbuf_d;
      control_q   <= control_d;
      wt_arr_q    <= wt_arr_d;
      data_arr_q  <= data_arr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, counters and tile buffers.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    w_d     = w_q;
    dbuf_d  = dbuf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = w_tile;
          cnt_d   = '0;
          state_d = S_LOAD_W;
        end
      end

      S_LOAD_W: begin
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        cnt_d   = '0;
        state_d = S_FILL;
      end

      S_FILL: begin
        // in_ready_q is high throughout FILL, so this is the real handshake.
        if (in_valid && in_ready_q) begin
          dbuf_d[cnt_q] = in_data;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            t_d     = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_ISSUE: begin
        t_d = t_q + 1'b1;
        if (t_q == TW'(2 * N - 2)) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // t keeps counting so the capture windows stay aligned to issue t=0.
        t_d = t_q + 1'b1;
        if (t_q == TW'(T_LAST)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        t_d     = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result de-skew. Column j of data column k appears on res_in at
  // t = RES_LAT+k+j, but all columns of k must leave together after column N-1
  // is seen at t = RES_LAT+k+N-1. Column j therefore needs N-1-j cycles of
  // delay; a shift line of that depth per column gives each k its own slot, so
  // a later k never overwrites a value still waiting for its vector.
  // Capture runs purely from t while an issue/drain is in flight.
  // ---------------------------------------------------------------------------
  logic              cap_run;
  logic [ACCW-1:0]   skew_tail [N];

  assign cap_run = (state_q == S_ISSUE) || (state_q == S_DRAIN);

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_skew
      localparam int DEPTH = N - 1 - gi;
      logic [ACCW-1:0] sk_q [DEPTH];
      logic [ACCW-1:0] sk_d [DEPTH];

      always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
          sk_d[s] = sk_q[s];
        end
        if (cap_run) begin
          sk_d[0] = res_in[gi*ACCW +: ACCW];
          for (int s = 1; s < DEPTH; s++) begin
            sk_d[s] = sk_q[s-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < DEPTH; s++) begin
            sk_q[s] <= '0;
          end
        end else begin
          sk_q <= sk_d;
        end
      end

      assign skew_tail[gi] = sk_q[DEPTH-1];
    end
  endgenerate

  // The last column needs no delay: it is taken straight from the array.
  assign skew_tail[N-1] = res_in[(N-1)*ACCW +: ACCW];

  // ---------------------------------------------------------------------------
  // Output logic. Outputs are registered, so they are decoded from the
  // next state / next counters to line up with the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin : p_out
    int k;
    k          = 0;
    control_d  = (state_d == S_LOAD_W) || (state_d == S_SETTLE);
    in_ready_d = (state_d == S_FILL);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);

    // Weight lane r carries W[r][cnt]; w_d is used so the first column is
    // correct on the very cycle the tile is accepted.
    wt_arr_d = '0;
    if (state_d == S_LOAD_W) begin
      for (int r = 0; r < N; r++) begin
        wt_arr_d[r*DW +: DW] = w_d[(int'(cnt_d) * N + r) * DW +: DW];
      end
    end

    // Lane i carries D[i][t-i] inside its diagonal window, zero outside.
    // dbuf_d covers the case where the needed beat is accepted this cycle.
    data_arr_d = '0;
    if (state_d == S_ISSUE) begin
      for (int i = 0; i < N; i++) begin
        k = int'(t_d) - i;
        if (k >= 0 && k < N) begin
          data_arr_d[i*DW +: DW] = dbuf_d[k[CW-1:0]][i*DW +: DW];
        end
      end
    end

    // A vector is complete on the cycle column N-1 of some k is sampled.
    out_valid_d = cap_run && (t_q >= TW'(RES_LAT + N - 1)) &&
                  (t_q <= TW'(T_LAST - 1));
    out_data_d  = out_data_q;
    if (out_valid_d) begin
      for (int j = 0; j < N; j++) begin
        out_data_d[j*ACCW +: ACCW] = skew_tail[j];
      end
    end
  end

  assign control   = control_q;
  assign wt_arr    = wt_arr_q;
  assign data_arr  = data_arr_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for mmu_sequencer (N=4, DW=8, ACCW=24, RES_LAT=4).
// A per-cycle vector table holds the stimulus and expected outputs of one
// complete tile; a stub array model drives res_in from the issue-relative time.
// Hand-written sequences cover reset and an asynchronous reset mid-issue.
// -----------------------------------------------------------------------------
module tb_mmu_sequencer;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int ACCW    = 24;
  localparam int RES_LAT = 4;
  localparam int NV      = 27;  // cycles in one full tile sequence
  localparam int T0      = 13;  // table cycle of issue t=0

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [N*N*DW-1:0]   w_tile;
  logic                in_valid;
  logic                in_ready;
  logic [N*DW-1:0]     in_data;
  logic                control;
  logic [N*DW-1:0]     wt_arr;
  logic [N*DW-1:0]     data_arr;
  logic [N*ACCW-1:0]   res_in;
  logic                out_valid;
  logic [N*ACCW-1:0]   out_data;
  logic                busy;
  logic                done;

  int checks   = 0;
  int failures = 0;

  mmu_sequencer #(.N(N), .DW(DW), .ACCW(ACCW), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .w_tile(w_tile),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
    .res_in(res_in), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        e_control;
    logic [31:0] e_wt;
    logic [31:0] e_data;
    logic        e_in_ready;
    logic        e_busy;
    logic        e_done;
    logic        e_out_valid;
    logic [95:0] e_out;
  } vec_t;

  vec_t        vecs [NV];
  logic [31:0] beats [N];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stub array: column j of data column k appears at t = RES_LAT+k+j;
  // outside those windows a poison value is driven.
  task automatic drive_stub(input int t);
    for (int j = 0; j < N; j++) begin
      int k;
      k = t - RES_LAT - j;
      if (t >= 0 && k >= 0 && k < N)
        res_in[j*ACCW +: ACCW] = 24'((j << 8) | k);
      else
        res_in[j*ACCW +: ACCW] = 24'hE0E0E0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " control"},   96'(control),   96'd0);
    chk({tag, " wt_arr"},    96'(wt_arr),    96'd0);
    chk({tag, " data_arr"},  96'(data_arr),  96'd0);
    chk({tag, " in_ready"},  96'(in_ready),  96'd0);
    chk({tag, " out_valid"}, 96'(out_valid), 96'd0);
    chk({tag, " out_data"},  96'(out_data),  96'd0);
    chk({tag, " busy"},      96'(busy),      96'd0);
    chk({tag, " done"},      96'(done),      96'd0);
  endtask

  task automatic run_table(input int pass);
    for (int c = 0; c < NV; c++) begin
      @(posedge clk);
      #2;
      start    = vecs[c].start;
      in_valid = vecs[c].in_valid;
      in_data  = vecs[c].in_data;
      drive_stub(c - T0);
      @(negedge clk);
      chk($sformatf("p%0d c%0d control", pass, c),  96'(control),  96'(vecs[c].e_control));
      chk($sformatf("p%0d c%0d wt_arr", pass, c),   96'(wt_arr),   96'(vecs[c].e_wt));
      chk($sformatf("p%0d c%0d data_arr", pass, c), 96'(data_arr), 96'(vecs[c].e_data));
      chk($sformatf("p%0d c%0d in_ready", pass, c), 96'(in_ready), 96'(vecs[c].e_in_ready));
      chk($sformatf("p%0d c%0d busy", pass, c),     96'(busy),     96'(vecs[c].e_busy));
      chk($sformatf("p%0d c%0d done", pass, c),     96'(done),     96'(vecs[c].e_done));
      chk($sformatf("p%0d c%0d out_valid", pass, c), 96'(out_valid), 96'(vecs[c].e_out_valid));
      if (vecs[c].e_out_valid) begin
        chk($sformatf("p%0d c%0d out_data", pass, c), out_data, vecs[c].e_out);
        $display("pass %0d cycle %0d result vector out_data=%h", pass, c, out_data);
      end
    end
    #2;
    start    = 1'b0;
    in_valid = 1'b0;
    res_in   = '0;
  endtask

  initial begin
    // ---- vector table --------------------------------------------------------
    beats[0] = 32'h0c080400;
    beats[1] = 32'h0d090501;
    beats[2] = 32'h0e0a0602;
    beats[3] = 32'h0f0b0703;

    for (int c = 0; c < NV; c++) begin
      vecs[c].start       = 1'b0;
      vecs[c].in_valid    = 1'b0;
      vecs[c].in_data     = 32'hA5A5A5A5;
      vecs[c].e_control   = (c >= 1 && c <= 5);
      vecs[c].e_wt        = 32'h0;
      vecs[c].e_data      = 32'h0;
      vecs[c].e_in_ready  = (c >= 6 && c <= 12);
      vecs[c].e_busy      = (c >= 1 && c <= 25);
      vecs[c].e_done      = (c == 25);
      vecs[c].e_out_valid = (c >= 21 && c <= 24);
      vecs[c].e_out       = '0;
      if (c >= 21 && c <= 24)
        for (int j = 0; j < N; j++)
          vecs[c].e_out[j*ACCW +: ACCW] = 24'((j << 8) | (c - 21));
    end
    vecs[0].start  = 1'b1;
    vecs[7].start  = 1'b1;   // during FILL: ignored
    vecs[15].start = 1'b1;   // during ISSUE: ignored
    vecs[1].e_wt = 32'h00000001;
    vecs[2].e_wt = 32'h00000100;
    vecs[3].e_wt = 32'h00010000;
    vecs[4].e_wt = 32'h01000000;
    // in_valid pattern 1,0,0,1,1,0,1 over FILL cycles 6..12
    vecs[6].in_valid  = 1'b1; vecs[6].in_data  = beats[0];
    vecs[9].in_valid  = 1'b1; vecs[9].in_data  = beats[1];
    vecs[10].in_valid = 1'b1; vecs[10].in_data = beats[2];
    vecs[12].in_valid = 1'b1; vecs[12].in_data = beats[3];
    vecs[13].e_data = 32'h00000000;
    vecs[14].e_data = 32'h00000401;
    vecs[15].e_data = 32'h00080502;
    vecs[16].e_data = 32'h0c090603;
    vecs[17].e_data = 32'h0d0a0700;
    vecs[18].e_data = 32'h0e0b0000;
    vecs[19].e_data = 32'h0f000000;

    // identity weight tile: W[r][c]=1 iff r==c, at bits (c*N+r)*DW
    w_tile = '0;
    for (int r = 0; r < N; r++) w_tile[(r * N + r) * DW +: DW] = 8'd1;

    // ---- reset -------------------------------------------------------------
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; res_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");
    $display("reset state checked");

    // ---- full tile, table driven -----------------------------------------------
    run_table(1);
    $display("tile pass 1 complete");

    // ---- asynchronous reset at issue t=3 ---------------------------------------
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk);
      #2;
      start    = (c == 0);
      in_valid = (c >= 6 && c <= 9);
      in_data  = (c >= 6 && c <= 9) ? beats[c - 6] : 32'hA5A5A5A5;
      res_in   = '0;
    end
    @(negedge clk);
    chk("pre_reset t3 data_arr", 96'(data_arr), 96'(32'h0c090603));
    chk("pre_reset t3 busy", 96'(busy), 96'd1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    $display("async reset mid-issue applied");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset c%0d out_valid", c), 96'(out_valid), 96'd0);
      chk($sformatf("post_reset c%0d done", c), 96'(done), 96'd0);
    end

    // ---- full tile again after the abandoned one --------------------------------
    run_table(2);
    $display("tile pass 2 complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmu_sequencer.md
Name: mmu_sequencer

Overview:
Controller that sequences the N x N systolic TPU array used by the brightness filter.
- Loads one weight tile into the array column by column.
- Buffers one data tile, then issues it to the array with per-lane skew.
- Captures the bottom-row PE outputs and re-aligns them into one full result vector per data column.
- Sits between the filter front-end (tile source/sink) and the TPU instance, and is the only driver of the TPU's control, wt_arr and data_arr.

Parameters:
N, 4, array dimension (lanes, rows and columns).
DW, 8, weight/data element width.
ACCW, 24, width of each bottom-row PE result.
RES_LAT, 4, cycles from issue cycle 0 to column-0 result of data column 0 (must be >= 1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  begin one tile operation; sampled only in IDLE.
w_tile  in  N*N*DW  weight tile, sampled on accepted start; W[r][c] at bits [(c*N+r)*DW +: DW].
in_valid  in  1  data beat valid.
in_ready  out  1  sequencer accepts a data beat.
in_data  in  N*DW  data beat r; byte i = D[i][r].
control  out  1  to TPU: 1 = weight load, 0 = compute.
wt_arr  out  N*DW  to TPU weight bus.
data_arr  out  N*DW  to TPU data bus.
res_in  in  N*ACCW  from TPU bottom row; column j at [j*ACCW +: ACCW].
out_valid  out  1  one-cycle strobe per result vector.
out_data  out  N*ACCW  de-skewed result vector; column j at [j*ACCW +: ACCW].
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at end of tile.

Behaviour:
- Reset (async, any state): state=IDLE. control, wt_arr, data_arr, in_ready, out_valid, out_data, busy and done all 0. Buffers and counters cleared. An operation interrupted by reset is abandoned; the array is not drained.
- All outputs are registered. Counters are ceil(log2) sized and wrap only on explicit reload.
- IDLE:
  - start=1 -> capture w_tile, go to LOAD_W, cnt=0.
  - start while busy is ignored.
- LOAD_W (N cycles): control=1; wt_arr lane r = W[r][cnt]. cnt=N-1 -> SETTLE.
- SETTLE (1 cycle): control=1, wt_arr=0. Then -> FILL.
  - Net effect: control is high for exactly N+1 cycles.
- FILL:
  - control=0, data_arr=0, in_ready=1.
  - Each in_valid&in_ready stores beat r (r = 0..N-1).
  - Gaps in in_valid simply wait; there is no timeout.
  - After beat N-1 is accepted, in_ready drops in the same cycle the beat is taken -> ISSUE, t=0.
  - in_ready is 0 in every other state.
- ISSUE (2N-1 cycles, t = 0..2N-2):
  - data_arr lane i = D[i][t-i] if 0 <= t-i < N, else 0. Never X.
  - The array has no stall, so issue is uninterruptible.
- Capture:
  - Column j result for data column k is sampled from res_in at t = RES_LAT+k+j, measured from issue t=0. The t counter keeps running through DRAIN.
  - A per-column capture register holds the value until column N-1 of the same k is taken.
  - out_valid=1 and out_data=all N columns for k in the cycle after the column N-1 sample (t = RES_LAT+k+N).
  - There is no backpressure on the output; the sink must accept every beat.
- DRAIN: data_arr=0; waits for the last vector (k=N-1). Then -> DONE.
- DONE (1 cycle): done=1, busy=1. Then -> IDLE.
  - start is accepted again the following cycle.
- ISSUE/DRAIN overlap: if RES_LAT < 2N-1, captures begin during ISSUE. Capture logic is independent of the issue-state decode.
- Weights persist in the array. A new start always reloads them; there is no weight-reuse mode.

Test Plan:
- Identity tile (W[r][c]=1 iff r==c), N=4, start -> control=1 for exactly 5 cycles. wt_arr = 0x00000001, 0x00000100, 0x00010000, 0x01000000, then 0x00000000. busy=1 from the next cycle.
- Data beats 0x0c080400, 0x0d090501, 0x0e0a0602, 0x0f0b0703 -> data_arr over ISSUE = 0x00000000, 0x00000401, 0x00080502, 0x0c090603, 0x0d0a0700, 0x0e0b0000, 0x0f000000, then 0.
- Stub array drives res_in column j = (j<<8)|k at t = RES_LAT+k+j -> 4 out_valid strobes at t = 8, 9, 10, 11. Beat k carries columns {k, 0x100|k, 0x200|k, 0x300|k}. done pulses at t=12.
- in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 beats stored in order. ISSUE starts the cycle after the 4th accept. in_ready=0 during LOAD_W, SETTLE, ISSUE, DRAIN and DONE.
- start pulsed during FILL and ISSUE -> ignored; wt_arr and control are unchanged.
- rst asserted mid-ISSUE (t=3), asynchronously between clock edges -> all outputs 0 before the next edge, and no out_valid or done afterwards. A following start runs the full sequence with correct values.
